// File: rtl/i2c_pkg.sv
// Shared types and constants for the simple I2C target.
//   i2c_tgt_state_t : protocol state of the target FSM
//   I2C_RW_*        : value of the R/W bit that follows the 7-bit address
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX_LOAD,
        TX,
        TX_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge detector for one open-drain I2C line.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous pad level
//   level      : synchronised level (second flop)
//   rise, fall : single-cycle pulses on synchronised transitions
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Reset to the idle bus level so releasing reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_target_simple.sv
// Simple I2C target: fixed 7-bit address, byte write to a parallel port,
// byte read from a parallel port, no clock stretching.
//   clk, rst_n : system clock (>= 8x SCL), asynchronous active-low reset
//   scl_in     : SCL pad level (input only)
//   sda_in     : SDA pad level (wired-AND)
//   sda_oe     : 1 pulls SDA low, 0 releases it
//   rx_data    : last received write byte, rx_valid pulses when it updates
//   tx_data    : read byte, sampled the cycle after the tx_req pulse
//   tx_req     : pulse requesting the next read byte
//   busy       : high from address acknowledge until STOP or repeated START
module i2c_target_simple
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scl_in),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sda_in),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_cond;
    logic stop_cond;

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    i2c_tgt_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           sda_oe_q, sda_oe_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           tx_req_q, tx_req_d;
    logic           busy_q, busy_d;
    logic           rw_q, rw_d;
    // Second half of a two-step phase: ACK driven (ADDR_ACK/RX_ACK) or
    // master ACK seen and waiting for the closing SCL fall (TX_ACK).
    logic           phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= I2C_RW_WRITE;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        phase_d    = phase_q;

        // Bus conditions win over any bit-level activity in the same cycle.
        if (stop_cond) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
        end else if (start_cond) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_level};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_level;
                            phase_d = 1'b0;
                            // shreg_q[6:0] already holds the 7 address bits.
                            if ((shreg_q[6:0] == TARGET_ADDR) && (TARGET_ADDR != 7'h00)) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            if (rw_q == I2C_RW_WRITE) begin
                                state_d   = RX;
                                bit_cnt_d = 3'd0;
                            end else begin
                                tx_req_d = 1'b1;
                                state_d  = TX_LOAD;
                            end
                        end
                    end
                end

                RX: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_level};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shreg_q[6:0], sda_level};
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end

                RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = RX;
                        end
                    end
                end

                TX_LOAD: begin
                    // Hold off while the request pulse is still out so tx_data
                    // is taken on the cycle after tx_req.
                    if (!tx_req_q) begin
                        shreg_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 3'd0;
                        state_d   = TX;
                    end
                end

                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = TX_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                TX_ACK: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (!sda_level) begin
                                tx_req_d = 1'b1;
                                phase_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        phase_d = 1'b0;
                        state_d = TX_LOAD;
                    end
                end

                IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: doc/i2c_target_simple.md
# i2c_target_simple

Simple I2C target (responder) for the far end of our `i2c_master_simple` bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it; rejects any other address without touching the bus.
- Write: receives data bytes and presents each on a parallel port. Read: serialises bytes fetched from a parallel port.
- SDA is open-drain via `sda_oe`; SCL is input only, with no clock stretching.

## Interface
- `TARGET_ADDR`, default 7'h42: 7-bit address this target answers to.
- `clk`  in  1: system clock; must be ≥ 8× SCL frequency.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `scl_in`  in  1: SCL pad level, asynchronous.
- `sda_in`  in  1: SDA pad level, asynchronous (wired-AND result).
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release.
- `rx_data`  out  8: last received write byte; held until the next one.
- `rx_valid`  out  1: 1-clk pulse when `rx_data` updates.
- `tx_data`  in  8: read byte, sampled on `tx_req` cycle +1.
- `tx_req`  out  1: 1-clk pulse requesting the next read byte.
- `busy`  out  1: high from address match until STOP or repeated START.

## Operation
- Synchronisation:
  - SCL and SDA each pass through 2 flops plus 1 history flop.
  - `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall` are derived from the synchronised values.
- Bus conditions:
  - START = `sda_fall` while synced SCL = 1.
  - STOP = `sda_rise` while synced SCL = 1.
  - Both are checked before bit logic and override every state.
- Bit timing:
  - Data is sampled on `scl_rise`, MSB first.
  - `sda_oe` changes only on `scl_fall` (or at STOP/START).
- States (`bit_cnt` 3-bit, `shreg` 8-bit):
  - IDLE: `sda_oe`=0; START → ADDR, `bit_cnt`=0.
  - ADDR: shift 8 bits; on the 8th `scl_rise` compare `shreg[7:1]` with `TARGET_ADDR`. Match → ADDR_ACK; mismatch → IGNORE.
  - ADDR_ACK: on `scl_fall` set `sda_oe`=1, `busy`=1. On the next `scl_fall`, if R/W=0 go to RX with `sda_oe`=0. If R/W=1 pulse `tx_req` and go to TX_LOAD.
  - RX: shift 8 bits. On the 8th `scl_rise`, `rx_data`←byte and pulse `rx_valid`, then go to RX_ACK.
  - RX_ACK: on `scl_fall` set `sda_oe`=1. On the next `scl_fall` set `sda_oe`=0 and return to RX.
  - TX_LOAD: one clk; `shreg`←`tx_data`, `sda_oe`←~`tx_data[7]`, then go to TX.
  - TX: on each `scl_fall` shift and drive `sda_oe`=~bit. After bit 0 is clocked, at `scl_fall` set `sda_oe`=0 and go to TX_ACK.
  - TX_ACK: sample master ACK on `scl_rise`. ACK (SDA=0) → pulse `tx_req`, wait for `scl_fall`, go to TX_LOAD. NACK → IGNORE.
  - IGNORE: `sda_oe`=0; wait for STOP or START.
- STOP from any state → IDLE, `busy`=0, `sda_oe`=0.
- START from any state (repeated START) → ADDR, `busy`=0, `sda_oe`=0.
- A partial byte interrupted by START or STOP is discarded; no `rx_valid` is issued.
- General call (address 0) is not supported and is treated as a mismatch.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0; state IDLE.
- Pad-to-detect latency is 3 clk; `sda_oe` asserts on the clk after the detected edge.
- `rx_valid` asserts 1 clk after the internal `scl_rise` of bit 0.
- `tx_data` must be valid on the clk after `tx_req`. It is captured exactly once per byte.
- Reset mid-transfer releases SDA immediately (asynchronous). After reset the block waits in IDLE for a fresh START.
- Simultaneous STOP and `scl_rise` in one clk cannot occur on a legal bus; STOP has priority.

## Structure
- Package `i2c_pkg`:
  - `i2c_tgt_state_t` enum: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK, IGNORE.
  - Constants `I2C_RW_WRITE`=0, `I2C_RW_READ`=1.
- Sub-module `i2c_line_sync`, instantiated twice (SCL and SDA):
  - 2-flop synchroniser plus history flop.
  - Outputs: level, rise, fall.

## Test plan
- Write: master drives START, 0x42/W, bytes 0xA5, 0x3C, STOP → ACK on all three bytes. `rx_valid` pulses twice with `rx_data` 0xA5 then 0x3C. `busy` drops at STOP.
- Mismatch: START, 0x43/W, 0xFF, STOP → `sda_oe` stays 0 throughout; no `rx_valid`; `busy` stays 0.
- Read: START, 0x42/R; bench answers each `tx_req` with 0x96 then 0x5A; master ACKs the first byte and NACKs the second → SDA carries 0x96, 0x5A. Exactly two `tx_req` pulses. State is IGNORE after the NACK, IDLE after STOP.
- Repeated START: write 0x42/W plus 0x11, then Sr, 0x42/R, then STOP → one `rx_valid` (0x11), then the read path runs with one `tx_req` before the master NACK.
- Abort: STOP after 4 bits of a data byte → no `rx_valid`, `sda_oe`=0, state IDLE within 4 clk.
- Reset mid-ACK: assert `rst_n`=0 while `sda_oe`=1 → `sda_oe`=0 the same cycle. The next valid transaction is accepted normally.
